mapu_nxn: RTL and testbench
===========================

# mapu_nxn

Parametrised matrix arithmetic unit operating on DIM×DIM matrices of unsigned integers. It is the configurable successor to the fixed 4×4 matrix APU and adds a subtract and a transpose mode, an iterative row-per-cycle compute engine, a matrix-wide overflow flag, and a last-row marker. It sits between an upstream row producer and a downstream row consumer. Both sides use valid/ready row streams; one matrix row moves per handshake.

## Interface
- DATA_WIDTH, 32: width of one matrix element (4..64).
- DIM, 4: matrix dimension, DIM×DIM elements (2..8).
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- i_en  in  1  block enable; low freezes all state.
- i_op  in  2  operation: 0 ADD (A+B), 1 SUB (A−B), 2 MULT (A×B), 3 TRANS (Aᵀ); sampled on the A row 0 handshake.
- i_vld  in  1  input row valid.
- o_rdy  out  1  block can accept an input row.
- i_row  in  DIM*DATA_WIDTH  input row; element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- o_vld  out  1  output row valid.
- i_rdy  in  1  downstream accepts output row.
- o_row  out  DIM*DATA_WIDTH  output row, same packing as i_row.
- o_last  out  1  marks result row DIM−1 (qualified by o_vld).
- o_of  out  1  overflow of the current result matrix (qualified by o_vld).

## Operation
- States: LOAD → COMPUTE → UNLOAD → LOAD.
- LOAD:
  - o_rdy = i_en. In-handshake = i_vld & o_rdy.
  - Beats 0..DIM−1 fill A rows 0..DIM−1; beats DIM..2·DIM−1 fill B.
  - All 2·DIM beats are required for every op; B is ignored for TRANS.
  - Op is latched on beat 0. After beat 2·DIM−1 the block goes to COMPUTE.
- COMPUTE:
  - Exactly DIM cycles; cycle r writes result row C[r].
  - ADD: C[r][j] = A[r][j]+B[r][j].
  - SUB: C[r][j] = A[r][j]−B[r][j].
  - MULT: C[r][j] = Σk A[r][k]·B[k][j] (true matrix product).
  - TRANS: C[r][j] = A[j][r].
  - Results are truncated to DATA_WIDTH (modulo 2^DATA_WIDTH).
- Overflow rules (sticky over the whole matrix, cleared on entry to COMPUTE):
  - ADD: carry out of the element sum.
  - SUB: borrow, i.e. A<B.
  - MULT: full-precision sum ≥ 2^DATA_WIDTH.
  - TRANS: never.
- UNLOAD:
  - Presents C rows 0..DIM−1 in order. o_of is constant for all rows.
  - Out-handshake = o_vld & i_rdy.
  - After the handshake on row DIM−1 (o_last=1), returns to LOAD.
- i_en low:
  - Forces o_rdy=0 and o_vld=0.
  - Freezes state, counters, matrices, and the latched op.
  - On i_en high, operation resumes with the same row.
- Reset: state LOAD, counters 0, A/B/C 0; a transfer in progress is discarded.

## Timing
- Reset values: o_rdy=0 during reset, then 1 from the first cycle after release if i_en=1. o_vld=0, o_row=0, o_last=0, o_of=0.
- o_rdy is decoded combinationally from state and i_en. o_vld, o_row, o_last and o_of are registered.
- Latency: last B beat accepted at cycle t. COMPUTE runs cycles t+1..t+DIM. o_vld=1 with row 0 at cycle t+DIM+1.
- Out-handshake at cycle u on a non-last row: next row is presented at u+1, so rows stream back-to-back when i_rdy stays high.
- While o_vld=1 and i_rdy=0 (and i_en=1): o_row, o_last and o_of stay stable.
- Last out-handshake at cycle u: o_vld=0 and o_rdy=1 at u+1. Load and unload never overlap.
- i_vld while not in LOAD: ignored, no data captured.
- i_en falling during UNLOAD with o_vld=1: o_vld drops the next cycle; the same row is re-presented after i_en rises.
- reset_n low on any cycle: the next cycle shows reset values regardless of i_en.

## Test plan
- DIM=4, DW=32, ADD, A[r][j]=4r+j, B=all 1 → after 4-cycle compute, rows {1,2,3,4}…{13,14,15,16}; o_last on row 3; o_of=0.
- MULT, A=[[1,2],[3,4]], B=[[5,6],[7,8]] (DIM=2) → rows {19,22},{43,50}, first o_vld 3 cycles after the last B beat.
- DW=8, ADD of 200+100 in one element → that element reads 44; o_of=1 on every row. SUB with A<B → wrapped result, o_of=1.
- TRANS, DIM=4, A[r][j]=4r+j, B=arbitrary → row r = {r, r+4, r+8, r+12}; o_of=0.
- Random i_rdy gaps and i_en low for 3 cycles mid-LOAD and mid-UNLOAD → no lost, duplicated or reordered rows; o_row stable while stalled; results unchanged.
- reset_n low for 1 cycle during UNLOAD row 2 → o_vld=0 next cycle, o_rdy=1 after release; the next full load produces the correct fresh result.

Source files
------------

// File: rtl/mapu_nxn.sv
// mapu_nxn - parametrised DIM x DIM matrix arithmetic unit.
//
// Purpose: accepts two DIM x DIM matrices A and B as a stream of rows,
// computes one result row per cycle (ADD, SUB, MULT, TRANS) and streams the
// result matrix C back out one row per handshake.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   i_en     in   block enable; low freezes all state and drops o_vld
//   i_op     in   0 ADD, 1 SUB, 2 MULT, 3 TRANS; sampled on A row 0
//   i_vld    in   input row valid
//   o_rdy    out  block can accept an input row (combinational)
//   i_row    in   input row, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   o_vld    out  output row valid
//   i_rdy    in   downstream accepts output row
//   o_row    out  output row, same packing as i_row
//   o_last   out  marks result row DIM-1
//   o_of     out  overflow seen anywhere in the current result matrix
module mapu_nxn #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_en,
  input  logic [1:0]                i_op,
  input  logic                      i_vld,
  output logic                      o_rdy,
  input  logic [DIM*DATA_WIDTH-1:0] i_row,
  output logic                      o_vld,
  input  logic                      i_rdy,
  output logic [DIM*DATA_WIDTH-1:0] o_row,
  output logic                      o_last,
  output logic                      o_of
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(2 * DIM);
  // Wide enough for a full-precision sum of DIM products.
  localparam int SW = 2 * DATA_WIDTH + $clog2(DIM) + 1;

  localparam logic [CW-1:0] BEAT_LAST = CW'(2 * DIM - 1);
  localparam logic [CW-1:0] BEAT_B    = CW'(DIM);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DIM - 1);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MULT, OP_TRANS} op_t;
  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

  state_t                    r_state;
  op_t                       r_op;
  logic [CW-1:0]             r_beat;
  logic [RW-1:0]             r_cnt;
  logic [DATA_WIDTH-1:0]     r_a [DIM][DIM];
  logic [DATA_WIDTH-1:0]     r_b [DIM][DIM];
  logic [DATA_WIDTH-1:0]     r_c [DIM][DIM];
  logic                      r_of_acc;
  logic                      r_vld;
  logic                      r_last;
  logic                      r_of;
  logic [DIM*DATA_WIDTH-1:0] r_row;

  logic [DATA_WIDTH-1:0]     w_in  [DIM];
  logic [DATA_WIDTH-1:0]     w_res [DIM];
  logic [DIM-1:0]            w_of;
  logic                      w_is_b;
  logic [RW-1:0]             w_ld_row;
  logic [RW-1:0]             w_cnt_inc;
  logic [RW-1:0]             w_sel;
  logic [DIM*DATA_WIDTH-1:0] w_cpack;

  assign o_rdy  = reset_n & i_en & (r_state == ST_LOAD);
  assign o_vld  = r_vld;
  assign o_row  = r_row;
  assign o_last = r_last;
  assign o_of   = r_of;

  // Beats 0..DIM-1 go to A, DIM..2*DIM-1 go to B.
  assign w_is_b    = (r_beat >= BEAT_B);
  assign w_ld_row  = w_is_b ? RW'(r_beat - BEAT_B) : RW'(r_beat);
  assign w_cnt_inc = r_cnt + 1'b1;

  // Row of C to load into the output register: row 0 when compute finishes,
  // otherwise the row after the one being handed over.
  assign w_sel = ((r_state == ST_UNLOAD) && (r_cnt != ROW_LAST)) ? w_cnt_inc : '0;

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_col
      logic [DATA_WIDTH:0]   w_add;
      logic [DATA_WIDTH:0]   w_sub;
      logic [SW-1:0]         w_mac;
      logic [DATA_WIDTH-1:0] w_res_col;
      logic                  w_of_col;

      assign w_in[gi] = i_row[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_cpack[gi*DATA_WIDTH +: DATA_WIDTH] = r_c[w_sel][gi];

      // Extra top bit carries the add carry-out / subtract borrow.
      assign w_add = {1'b0, r_a[r_cnt][gi]} + {1'b0, r_b[r_cnt][gi]};
      assign w_sub = {1'b0, r_a[r_cnt][gi]} - {1'b0, r_b[r_cnt][gi]};

      always_comb begin
        w_mac = '0;
        for (int k = 0; k < DIM; k++) begin
          w_mac = w_mac + SW'(r_a[r_cnt][k]) * SW'(r_b[k][gi]);
        end
      end

      always_comb begin
        w_res_col = '0;
        w_of_col  = 1'b0;
        case (r_op)
          OP_ADD: begin
            w_res_col = w_add[DATA_WIDTH-1:0];
            w_of_col  = w_add[DATA_WIDTH];
          end
          OP_SUB: begin
            w_res_col = w_sub[DATA_WIDTH-1:0];
            w_of_col  = w_sub[DATA_WIDTH];
          end
          OP_MULT: begin
            w_res_col = w_mac[DATA_WIDTH-1:0];
            w_of_col  = |w_mac[SW-1:DATA_WIDTH];
          end
          default: begin
            w_res_col = r_a[gi][r_cnt];
          end
        endcase
      end

      assign w_res[gi] = w_res_col;
      assign w_of[gi]  = w_of_col;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_LOAD;
      r_op     <= OP_ADD;
      r_beat   <= '0;
      r_cnt    <= '0;
      r_of_acc <= 1'b0;
      r_vld    <= 1'b0;
      r_last   <= 1'b0;
      r_of     <= 1'b0;
      r_row    <= '0;
      for (int r = 0; r < DIM; r++) begin
        for (int j = 0; j < DIM; j++) begin
          r_a[r][j] <= '0;
          r_b[r][j] <= '0;
          r_c[r][j] <= '0;
        end
      end
    end else if (i_en) begin
      case (r_state)
        ST_LOAD: begin
          if (i_vld) begin
            for (int j = 0; j < DIM; j++) begin
              if (w_is_b) r_b[w_ld_row][j] <= w_in[j];
              else        r_a[w_ld_row][j] <= w_in[j];
            end
            if (r_beat == '0) r_op <= op_t'(i_op);
            if (r_beat == BEAT_LAST) begin
              r_beat   <= '0;
              r_cnt    <= '0;
              r_of_acc <= 1'b0;
              r_state  <= ST_COMPUTE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end

        ST_COMPUTE: begin
          for (int j = 0; j < DIM; j++) begin
            r_c[r_cnt][j] <= w_res[j];
          end
          r_of_acc <= r_of_acc | (|w_of);
          if (r_cnt == ROW_LAST) begin
            // Row 0 was written earlier, so it can be presented right away;
            // the flag folds in the row being written this cycle.
            r_state <= ST_UNLOAD;
            r_cnt   <= '0;
            r_vld   <= 1'b1;
            r_row   <= w_cpack;
            r_last  <= 1'b0;
            r_of    <= r_of_acc | (|w_of);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_UNLOAD: begin
          if (!r_vld) begin
            // Resuming after a disable: the held row is shown again.
            r_vld <= 1'b1;
          end else if (i_rdy) begin
            if (r_cnt == ROW_LAST) begin
              r_vld   <= 1'b0;
              r_last  <= 1'b0;
              r_cnt   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_cnt  <= w_cnt_inc;
              r_row  <= w_cpack;
              r_last <= (w_cnt_inc == ROW_LAST);
            end
          end
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end else begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mapu_nxn.sv
// tb_mapu_nxn - self-checking bench for mapu_nxn (DIM=4, DATA_WIDTH=8).
// A producer drives queued input beats, a consumer drives i_rdy, and a
// monitor checks every valid output row against a matrix-level model.
module tb_mapu_nxn;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int RWID = DW * N;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            i_en    = 1'b0;
  logic [1:0]      i_op    = 2'd0;
  logic            i_vld   = 1'b0;
  logic            i_rdy   = 1'b0;
  logic [RWID-1:0] i_row   = '0;
  logic            o_rdy;
  logic            o_vld;
  logic            o_last;
  logic            o_of;
  logic [RWID-1:0] o_row;

  mapu_nxn #(.DATA_WIDTH(DW), .DIM(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (i_en),
    .i_op    (i_op),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_row   (i_row),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_row   (o_row),
    .o_last  (o_last),
    .o_of    (o_of)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Input beats (written by the main process, consumed by the monitor).
  logic [RWID-1:0] beat_row [0:1023];
  logic [1:0]      beat_op  [0:1023];
  int              beat_wr = 0;
  int              beat_rd = 0;

  // Expected result rows.
  logic [RWID-1:0] exp_row  [0:255];
  logic            exp_last [0:255];
  logic            exp_of   [0:255];
  int              exp_wr = 0;
  int              exp_rd = 0;

  int ma [N][N];
  int mb [N][N];

  int rdy_mode = 0;
  bit vld_gaps = 1'b0;
  bit en_rand  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [RWID-1:0] pack_row(input int r, input bit is_b);
    logic [RWID-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      v[j*DW +: DW] = is_b ? DW'(mb[r][j]) : DW'(ma[r][j]);
    end
    return v;
  endfunction

  // Queue the 2*N input beats and the expected result matrix.
  task automatic push_matrix(input int op);
    longint          s;
    longint          lim;
    bit              of;
    logic [RWID-1:0] v;
    lim = longint'(1) << DW;
    for (int r = 0; r < N; r++) begin
      beat_row[beat_wr] = pack_row(r, 1'b0);
      beat_op[beat_wr]  = (r == 0) ? 2'(op) : 2'($urandom);
      beat_wr++;
    end
    for (int r = 0; r < N; r++) begin
      beat_row[beat_wr] = pack_row(r, 1'b1);
      beat_op[beat_wr]  = 2'($urandom);
      beat_wr++;
    end
    of = 1'b0;
    for (int r = 0; r < N; r++) begin
      v = '0;
      for (int j = 0; j < N; j++) begin
        case (op)
          0: begin
            s = longint'(ma[r][j]) + longint'(mb[r][j]);
            if (s >= lim) of = 1'b1;
          end
          1: begin
            s = longint'(ma[r][j]) - longint'(mb[r][j]);
            if (ma[r][j] < mb[r][j]) of = 1'b1;
          end
          2: begin
            s = 0;
            for (int k = 0; k < N; k++) s += longint'(ma[r][k]) * longint'(mb[k][j]);
            if (s >= lim) of = 1'b1;
          end
          default: s = longint'(ma[j][r]);
        endcase
        v[j*DW +: DW] = DW'(s);
      end
      exp_row[exp_wr + r]  = v;
      exp_last[exp_wr + r] = (r == N - 1);
    end
    for (int r = 0; r < N; r++) exp_of[exp_wr + r] = of;
    exp_wr += N;
  endtask

  task automatic clear_mats();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        ma[r][j] = 0;
        mb[r][j] = 0;
      end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_rd == exp_wr && beat_rd == beat_wr) break;
    end
    chk("drain_timeout", 64'(exp_wr - exp_rd), 64'd0);
  endtask

  // Producer / consumer / enable driver.
  initial begin
    int en_off;
    en_off = 0;
    forever begin
      @(posedge clk);
      #1;
      if (en_off > 0) begin
        i_en = 1'b0;
        en_off--;
      end else if (en_rand && $urandom_range(0, 39) == 0) begin
        i_en   = 1'b0;
        en_off = 2;
      end else begin
        i_en = 1'b1;
      end
      case (rdy_mode)
        0:       i_rdy = 1'b1;
        1:       i_rdy = 1'($urandom_range(0, 1));
        default: i_rdy = 1'b0;
      endcase
      if (beat_rd != beat_wr && (!vld_gaps || $urandom_range(0, 3) != 0)) begin
        i_vld = 1'b1;
        i_row = beat_row[beat_rd];
        i_op  = beat_op[beat_rd];
      end else begin
        i_vld = 1'b0;
        i_row = RWID'($urandom);
        i_op  = 2'($urandom);
      end
    end
  end

  // Monitor: beat acceptance, output row checks, latency and idle checks.
  initial begin
    bit armed;
    bit en_low;
    bit after_last;
    int t_last;
    int nbeats;
    armed = 0; en_low = 0; after_last = 0; t_last = 0; nbeats = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        beat_rd    = beat_wr;
        exp_rd     = exp_wr;
        armed      = 0;
        after_last = 0;
        nbeats     = 0;
        continue;
      end
      if (after_last) begin
        after_last = 0;
        chk("vld_after_last", 64'(o_vld), 64'd0);
        if (i_en) chk("rdy_after_last", 64'(o_rdy), 64'd1);
      end
      if (!i_en) en_low = 1;
      if (i_vld && o_rdy) begin
        beat_rd++;
        nbeats++;
        if (nbeats % (2 * N) == 0) begin
          armed  = 1;
          en_low = 0;
          t_last = cyc;
        end
      end
      if (o_vld) begin
        if (armed) begin
          if (!en_low) chk("latency", 64'(cyc - t_last), 64'(N + 1));
          armed = 0;
        end
        if (exp_rd == exp_wr) begin
          chk("spurious_row", 64'(o_vld), 64'd0);
        end else begin
          chk("o_row",  64'(o_row),  64'(exp_row[exp_rd]));
          chk("o_last", 64'(o_last), 64'(exp_last[exp_rd]));
          chk("o_of",   64'(o_of),   64'(exp_of[exp_rd]));
          if (i_rdy && i_en) begin
            $display("row %0d data=%h last=%0b of=%0b", exp_rd, o_row, o_last, o_of);
            if (exp_last[exp_rd]) after_last = 1;
            exp_rd++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int op;
    int rng;

    // Reset behaviour.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_rdy",  64'(o_rdy),  64'd0);
    chk("rst_o_vld",  64'(o_vld),  64'd0);
    chk("rst_o_row",  64'(o_row),  64'd0);
    chk("rst_o_last", 64'(o_last), 64'd0);
    chk("rst_o_of",   64'(o_of),   64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", 64'(o_rdy), 64'd1);

    // ADD, A[r][j]=4r+j, B=1.
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        ma[r][j] = 4 * r + j;
        mb[r][j] = 1;
      end
    push_matrix(0);
    chk("model_add_row0", 64'(exp_row[exp_wr-4]), 64'h04030201);
    chk("model_add_row3", 64'(exp_row[exp_wr-1]), 64'h100F0E0D);
    chk("model_add_of",   64'(exp_of[exp_wr-1]),  64'd0);
    wait_drain();

    // MULT of [[1,2],[3,4]] x [[5,6],[7,8]] in the top-left corner.
    clear_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    push_matrix(2);
    chk("model_mult_row0", 64'(exp_row[exp_wr-4]), 64'h00001613);
    chk("model_mult_row1", 64'(exp_row[exp_wr-3]), 64'h0000322B);
    wait_drain();

    // ADD overflow: 200+100 wraps to 44.
    clear_mats();
    ma[0][0] = 200; mb[0][0] = 100;
    push_matrix(0);
    chk("model_addof_row0", 64'(exp_row[exp_wr-4]), 64'h0000002C);
    chk("model_addof_flag", 64'(exp_of[exp_wr-2]),  64'd1);
    wait_drain();

    // SUB borrow: 3-5 wraps to 254.
    clear_mats();
    ma[1][1] = 3; mb[1][1] = 5;
    push_matrix(1);
    chk("model_sub_row1", 64'(exp_row[exp_wr-3]), 64'h0000FE00);
    chk("model_sub_flag", 64'(exp_of[exp_wr-4]),  64'd1);
    wait_drain();

    // TRANS with arbitrary B.
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        ma[r][j] = 4 * r + j;
        mb[r][j] = int'($urandom_range(0, 255));
      end
    push_matrix(3);
    chk("model_trans_row1", 64'(exp_row[exp_wr-3]), 64'h0D090501);
    chk("model_trans_of",   64'(exp_of[exp_wr-1]),  64'd0);
    wait_drain();

    // Randomised traffic with stalls, input gaps and enable drops; two
    // matrices are queued at once so beats wait while the block is busy.
    rdy_mode = 1;
    vld_gaps = 1'b1;
    en_rand  = 1'b1;
    for (int m = 0; m < 15; m++) begin
      for (int p = 0; p < 2; p++) begin
        op  = int'($urandom_range(0, 3));
        rng = ($urandom_range(0, 1) == 1) ? 15 : 255;
        for (int r = 0; r < N; r++)
          for (int j = 0; j < N; j++) begin
            ma[r][j] = int'($urandom_range(0, rng));
            mb[r][j] = int'($urandom_range(0, rng));
          end
        push_matrix(op);
      end
      wait_drain();
    end
    rdy_mode = 0;
    vld_gaps = 1'b0;
    en_rand  = 1'b0;
    wait_drain();

    // Reset during unload of row 2, then a fresh full transfer.
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        ma[r][j] = int'($urandom_range(0, 255));
        mb[r][j] = int'($urandom_range(0, 255));
      end
    base = exp_wr;
    push_matrix(2);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (o_vld && exp_rd == base + 2) break;
    end
    chk("reset_wait_row2", 64'(exp_rd - base), 64'd2);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("vld_after_reset", 64'(o_vld), 64'd0);
    chk("rdy_after_reset", 64'(o_rdy), 64'd1);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        ma[r][j] = int'($urandom_range(0, 255));
        mb[r][j] = int'($urandom_range(0, 255));
      end
    push_matrix(0);
    wait_drain();
    push_matrix(2);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
